bldc_commutation_sequencer: RTL and testbench

Six-step commutation sequencer for the BLDC drive. Takes the raw 3-bit Hall sensor inputs and produces the 6-bit per-switch `channel_enable` vector consumed by `pwm_commutator`, which gates the shared PWM onto the active switches. The block synchronises and debounces the Halls, enforces dead time between commutation patterns, and latches a fault on invalid or skipped Hall sequences.

---
 rtl/bldc_pkg.sv | 82 ++++++++
 rtl/hall_debouncer.sv | 68 ++++++
 rtl/bldc_commutation_sequencer.sv | 159 +++++++++++++++
 tb/tb_bldc_commutation_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bldc_pkg.sv
// Shared types and helpers for the BLDC six-step commutation sequencer.
// Holds the Hall/step encodings, the sequencer FSM state type and the
// pure functions that map Hall codes to steps and steps to switch patterns.
package bldc_pkg;

  // Debounced Hall code {C,B,A} and decoded electrical step.
  typedef logic [2:0] hall_t;
  typedef logic [2:0] step_t;

  // Step value reported for the two impossible Hall codes (000, 111).
  localparam step_t STEP_INVALID = 3'd7;

  // Number of electrical steps per revolution of the commutation table.
  localparam int STEP_COUNT = 6;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEADTIME,
    ST_DRIVE,
    ST_FAULT
  } commutation_state_t;

  // Hall code {C,B,A} to electrical step; 000 and 111 cannot occur on a
  // healthy sensor set and decode to STEP_INVALID.
  function automatic step_t hall_to_step(hall_t hall);
    step_t result;
    case (hall)
      3'b001:  result = 3'd0;
      3'b011:  result = 3'd1;
      3'b010:  result = 3'd2;
      3'b110:  result = 3'd3;
      3'b100:  result = 3'd4;
      3'b101:  result = 3'd5;
      default: result = STEP_INVALID;
    endcase
    return result;
  endfunction

  // True when step is one of the six valid positions.
  function automatic logic step_is_valid(step_t s);
    return (s < 3'd6);
  endfunction

  // Drive pattern for a step and rotation direction.
  // Bits [5:3] are the high-side switches {C,B,A}, bits [2:0] the low side.
  // Reverse rotation drives the pattern three steps (180 electrical degrees)
  // ahead of the forward one. Invalid steps map to all switches off.
  function automatic logic [5:0] step_to_pattern(step_t s, logic direction);
    step_t      drive_idx;
    logic [5:0] pattern;
    pattern = 6'b000_000;
    if (step_is_valid(s)) begin
      if (direction) begin
        drive_idx = (s >= 3'd3) ? (s - 3'd3) : (s + 3'd3);
      end else begin
        drive_idx = s;
      end
      case (drive_idx)
        3'd0:    pattern = 6'b001_010;  // A high, B low
        3'd1:    pattern = 6'b001_100;  // A high, C low
        3'd2:    pattern = 6'b010_100;  // B high, C low
        3'd3:    pattern = 6'b010_001;  // B high, A low
        3'd4:    pattern = 6'b100_001;  // C high, A low
        3'd5:    pattern = 6'b100_010;  // C high, B low
        default: pattern = 6'b000_000;
      endcase
    end
    return pattern;
  endfunction

  // True when two valid steps are neighbours on the six-step ring, i.e. the
  // rotor moved exactly one step in either direction.
  function automatic logic steps_adjacent(step_t a, step_t b);
    step_t a_next;
    step_t b_next;
    a_next = (a == 3'd5) ? 3'd0 : (a + 3'd1);
    b_next = (b == 3'd5) ? 3'd0 : (b + 3'd1);
    return (a_next == b) || (b_next == a);
  endfunction

endpackage

// File: rtl/hall_debouncer.sv
// Hall sensor front end: two-flop synchroniser for the asynchronous Hall
// pins followed by a stability filter. A new Hall code is accepted only after
// it has been seen unchanged for debounce_cycles consecutive cycles.
module hall_debouncer
  import bldc_pkg::*;
#(
  parameter int debounce_cycles = 64
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  [2:0] hall_i,
  output logic  [2:0] hall_o
);

  // Counter only needs to reach debounce_cycles-1 before the accept cycle.
  localparam int CNT_W = (debounce_cycles > 1) ? $clog2(debounce_cycles) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(debounce_cycles - 1);

  hall_t            sync1_q;
  hall_t            sync2_q;
  hall_t            sync_prev_q;
  hall_t            hall_q;
  hall_t            hall_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Stability filter: count cycles where the synchronised code differs from
  // the accepted one and did not move since the previous cycle. Any movement,
  // or a return to the accepted code, restarts the count.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    hall_d = hall_q;
    cnt_d  = '0;
    if ((sync2_q != hall_q) && (sync2_q == sync_prev_q)) begin
      if (cnt_q == CNT_LAST) begin
        hall_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser, change-detect history, stability counter and accepted code.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the synchroniser stages are cleared with everything else so the
      // accepted code starts at 000 (invalid) and a real Hall value must be
      // fully debounced before the sequencer can drive.
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync_prev_q <= '0;
      cnt_q       <= '0;
      hall_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge
      // values, which is what turns this chain into a real shift register.
      sync1_q     <= hall_i;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
      cnt_q       <= cnt_d;
      hall_q      <= hall_d;
    end
  end

  assign hall_o = hall_q;

endmodule

// File: rtl/bldc_commutation_sequencer.sv
// Six-step BLDC commutation sequencer. Debounced Hall position selects one of
// six switch patterns; every pattern change is preceded by an all-off dead
// time, and invalid or skipped Hall sequences latch a fault until the run
// request is dropped.
module bldc_commutation_sequencer #(
  parameter int debounce_cycles  = 64,
  parameter int dead_time_cycles = 50
) (
  input  logic       pwm_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       direction,
  input  logic [2:0] hall,
  output logic [5:0] channel_enable,
  output logic [2:0] step,
  output logic       commutation_strobe,
  output logic       fault
);

  import bldc_pkg::*;

  // Dead-time counter is loaded with dead_time_cycles-1 on DEADTIME entry and
  // the pattern is applied on the edge after it reads zero, which yields
  // exactly dead_time_cycles all-off output cycles.
  localparam int DT_W = (dead_time_cycles > 1) ? $clog2(dead_time_cycles) : 1;
  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(dead_time_cycles - 1);

  hall_t              hall_q;
  step_t              step_cur;
  logic               step_valid;
  logic [5:0]         target_pattern;

  commutation_state_t state_q;
  commutation_state_t state_d;
  logic [DT_W-1:0]    dt_cnt_q;
  logic [DT_W-1:0]    dt_cnt_d;
  step_t              applied_step_q;
  step_t              applied_step_d;

  logic [5:0]         channel_enable_q;
  logic [5:0]         channel_enable_d;
  logic               strobe_q;
  logic               strobe_d;
  logic               fault_q;
  logic               fault_d;

  hall_debouncer #(
    .debounce_cycles(debounce_cycles)
  ) u_hall_debouncer (
    .clk_i  (pwm_clk),
    .rst_i  (rst),
    .hall_i (hall),
    .hall_o (hall_q)
  );

  // Position decode and the pattern the current position/direction asks for.
  always_comb begin
    step_cur       = hall_to_step(hall_q);
    step_valid     = step_is_valid(step_cur);
    target_pattern = step_to_pattern(step_cur, direction);
  end

  // State register plus dead-time counter, last applied step and the
  // registered outputs.
  always_ff @(posedge pwm_clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      dt_cnt_q         <= '0;
      applied_step_q   <= '0;
      channel_enable_q <= '0;
      strobe_q         <= 1'b0;
      fault_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      dt_cnt_q         <= dt_cnt_d;
      applied_step_q   <= applied_step_d;
      channel_enable_q <= channel_enable_d;
      strobe_q         <= strobe_d;
      fault_q          <= fault_d;
    end
  end

  // Next-state logic; dropping enable wins over every other transition.
  always_comb begin
    state_d        = state_q;
    dt_cnt_d       = dt_cnt_q;
    applied_step_d = applied_step_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // An invalid position at start-up just waits; it is not a fault.
          if (step_valid) begin
            state_d  = ST_DEADTIME;
            dt_cnt_d = DT_LOAD;
          end
        end
        ST_DEADTIME: begin
          // The target may move while waiting; the counter is not restarted
          // and whatever position is current at expiry gets applied.
          if (!step_valid) begin
            state_d = ST_FAULT;
          end else if (dt_cnt_q == '0) begin
            state_d        = ST_DRIVE;
            applied_step_d = step_cur;
          end else begin
            dt_cnt_d = dt_cnt_q - DT_W'(1);
          end
        end
        ST_DRIVE: begin
          if (!step_valid) begin
            state_d = ST_FAULT;
          end else if (step_cur != applied_step_q) begin
            // A real rotor can only move to a neighbouring step.
            if (!steps_adjacent(step_cur, applied_step_q)) begin
              state_d = ST_FAULT;
            end else begin
              state_d  = ST_DEADTIME;
              dt_cnt_d = DT_LOAD;
            end
          end else if (target_pattern != channel_enable_q) begin
            // Same position but direction flipped: re-commutate via dead time.
            state_d  = ST_DEADTIME;
            dt_cnt_d = DT_LOAD;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output logic: switches are on only in DRIVE; a fresh pattern is loaded
  // (with a strobe) on DRIVE entry and held unchanged while DRIVE persists.
  always_comb begin
    channel_enable_d = '0;
    strobe_d         = 1'b0;
    fault_d          = (state_d == ST_FAULT);
    if (state_d == ST_DRIVE) begin
      if (state_q == ST_DRIVE) begin
        channel_enable_d = channel_enable_q;
      end else begin
        channel_enable_d = target_pattern;
        strobe_d         = 1'b1;
      end
    end
  end

  assign channel_enable     = channel_enable_q;
  assign step               = step_cur;
  assign commutation_strobe = strobe_q;
  assign fault              = fault_q;

endmodule

// File: tb/tb_bldc_commutation_sequencer.sv
// Self-checking bench for bldc_commutation_sequencer. Expected outputs come
// from an arithmetic model of the six-step table (phase indices, not a lookup
// of switch codes) and the documented latency rules for Hall, direction and
// enable events. Rotation direction and dwell times are randomised.
module tb_bldc_commutation_sequencer;

  localparam int N  = 4;  // debounce cycles
  localparam int DT = 3;  // dead-time cycles
  // Ticks from setting a new Hall value (just after an edge) until the
  // outputs go dark: 1 (first sample) + 2 (sync) + N (debounce) + 1 (FSM).
  localparam int HALL_LEAD = 4 + N;

  logic       pwm_clk;
  logic       rst;
  logic       enable;
  logic       direction;
  logic [2:0] hall;
  logic [5:0] channel_enable;
  logic [2:0] step;
  logic       commutation_strobe;
  logic       fault;

  int n_total = 0;
  int n_pass  = 0;

  logic [2:0] hall_of_step [6];
  int         cur_step;
  bit         cur_dir;
  logic [5:0] cur_pat;

  bldc_commutation_sequencer #(
    .debounce_cycles  (N),
    .dead_time_cycles (DT)
  ) dut (
    .pwm_clk            (pwm_clk),
    .rst                (rst),
    .enable             (enable),
    .direction          (direction),
    .hall               (hall),
    .channel_enable     (channel_enable),
    .step               (step),
    .commutation_strobe (commutation_strobe),
    .fault              (fault)
  );

  initial pwm_clk = 1'b0;
  always #5 pwm_clk = ~pwm_clk;

  // Model: drive index d -> high phase d/2, low phase ((d+1)/2+1) mod 3,
  // phases numbered A=0, B=1, C=2; reverse rotation shifts d by 3.
  function automatic logic [5:0] model_pattern(int s, bit dir);
    int d;
    int hi;
    int lo;
    logic [5:0] p;
    d  = dir ? (s + 3) % 6 : s;
    hi = d / 2;
    lo = ((d + 1) / 2 + 1) % 3;
    p  = '0;
    p[3 + hi] = 1'b1;
    p[lo]     = 1'b1;
    return p;
  endfunction

  task automatic tick();
    @(posedge pwm_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [5:0] observed,
                       input logic [5:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, observed, expected);
  endtask

  // Expected waveform around one commutation event: old pattern until the
  // lead time, DT all-off cycles, then the new pattern with a single strobe.
  task automatic expect_transition(input string tag, input logic [5:0] old_pat,
                                   input logic [5:0] new_pat, input int lead);
    logic [5:0] exp_ce;
    for (int j = 1; j <= lead + DT + 1; j++) begin
      tick();
      if (j < lead)           exp_ce = old_pat;
      else if (j < lead + DT) exp_ce = 6'd0;
      else                    exp_ce = new_pat;
      check({tag, "_ce"}, channel_enable, exp_ce);
      check({tag, "_strobe"}, 6'(commutation_strobe), 6'(j == lead + DT));
    end
    check({tag, "_fault"}, 6'(fault), 6'd0);
  endtask

  // Steady DRIVE: pattern held, no strobe.
  task automatic dwell(input string tag, input int cycles);
    for (int j = 0; j < cycles; j++) begin
      tick();
      check({tag, "_ce"}, channel_enable, cur_pat);
      check({tag, "_strobe"}, 6'(commutation_strobe), 6'd0);
    end
  endtask

  task automatic move_hall(input string tag, input int nxt);
    logic [5:0] new_pat;
    new_pat = model_pattern(nxt, cur_dir);
    hall    = hall_of_step[nxt];
    expect_transition(tag, cur_pat, new_pat, HALL_LEAD);
    check({tag, "_step"}, 6'(step), 6'(nxt));
    cur_step = nxt;
    cur_pat  = new_pat;
  endtask

  task automatic flip_direction(input string tag);
    logic [5:0] new_pat;
    cur_dir   = !cur_dir;
    direction = cur_dir;
    new_pat   = model_pattern(cur_step, cur_dir);
    expect_transition(tag, cur_pat, new_pat, 1);
    cur_pat = new_pat;
  endtask

  initial begin
    hall_of_step = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    // Reset with enable already high and Hall parked at 001.
    rst       = 1'b1;
    enable    = 1'b1;
    direction = 1'b0;
    hall      = 3'b001;
    tick();
    tick();
    check("rst_ce", channel_enable, 6'd0);
    check("rst_step", 6'(step), 6'd7);
    check("rst_strobe", 6'(commutation_strobe), 6'd0);
    check("rst_fault", 6'(fault), 6'd0);

    // Hall accepted N+2 cycles after the first post-reset sample.
    rst = 1'b0;
    repeat (2 + N) tick();
    check("step_before_accept", 6'(step), 6'd7);
    tick();
    check("step_first_valid", 6'(step), 6'd0);

    cur_step = 0;
    cur_dir  = 1'b0;
    cur_pat  = model_pattern(0, 0);
    expect_transition("startup", 6'd0, cur_pat, 1);
    check("startup_d0", channel_enable, 6'b001_010);

    // Forward rotation through all six steps, random dwell between changes.
    for (int i = 1; i <= 6; i++) begin
      dwell("fwd_dwell", $urandom_range(0, 4));
      move_hall("fwd", (cur_step + 1) % 6);
    end

    // Reverse direction at Hall 001 selects d3, then back to d0.
    flip_direction("dir_rev");
    check("rev_d3", channel_enable, 6'b010_001);
    flip_direction("dir_fwd");
    check("fwd_d0", channel_enable, 6'b001_010);

    // Two-cycle Hall glitch must be filtered out entirely.
    hall = 3'b011;
    tick();
    tick();
    hall = 3'b001;
    dwell("glitch", 12);
    check("glitch_step", 6'(step), 6'(cur_step));

    // Random walk: single-step moves either way plus direction flips.
    for (int i = 0; i < 12; i++) begin
      int action;
      action = $urandom_range(0, 2);
      dwell("walk_dwell", $urandom_range(0, 3));
      if (action == 0)      move_hall("walk_up", (cur_step + 1) % 6);
      else if (action == 1) move_hall("walk_dn", (cur_step + 5) % 6);
      else                  flip_direction("walk_dir");
    end

    // Reset mid-DRIVE: dark next cycle, then full re-debounce plus dead time.
    rst = 1'b1;
    tick();
    check("midrst_ce", channel_enable, 6'd0);
    check("midrst_step", 6'(step), 6'd7);
    check("midrst_strobe", 6'(commutation_strobe), 6'd0);
    rst = 1'b0;
    expect_transition("rst_redrive", 6'd0, cur_pat, HALL_LEAD);

    // Skipped step (two positions ahead) latches a fault.
    cur_step = (cur_step + 2) % 6;
    hall     = hall_of_step[cur_step];
    repeat (HALL_LEAD - 1) begin
      tick();
      check("skip_hold_ce", channel_enable, cur_pat);
    end
    tick();
    check("skip_fault", 6'(fault), 6'd1);
    check("skip_ce", channel_enable, 6'd0);
    check("skip_strobe", 6'(commutation_strobe), 6'd0);

    // One-cycle enable drop clears the fault and restarts from IDLE.
    enable = 1'b0;
    tick();
    check("clear_fault", 6'(fault), 6'd0);
    check("clear_ce", channel_enable, 6'd0);
    enable  = 1'b1;
    cur_pat = model_pattern(cur_step, cur_dir);
    expect_transition("recover", 6'd0, cur_pat, 1);

    // Hall 111 while driving: fault with outputs off.
    hall = 3'b111;
    repeat (HALL_LEAD) tick();
    check("h111_fault", 6'(fault), 6'd1);
    check("h111_ce", channel_enable, 6'd0);
    check("h111_step", 6'(step), 6'd7);

    // Clearing with an invalid Hall leaves the block idle, not faulted.
    enable = 1'b0;
    tick();
    check("h111_clear", 6'(fault), 6'd0);
    enable = 1'b1;
    repeat (5) begin
      tick();
      check("idle_invalid_ce", channel_enable, 6'd0);
      check("idle_invalid_fault", 6'(fault), 6'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
